// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store sequencer between the core and pu_ram.
// Checks each accepted access (funct3 legality, alignment, range), performs a
// one-cycle RAM strobe for legal accesses, extends load data and holds the
// response until the core takes it. All outputs are registered.
module lsu_ctrl #(
    parameter int RAM_BYTES = 256,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              re_out,
    output logic              we_out,
    output logic [1:0]        width_out,
    output logic [ADDR_W-1:0] addr_out,
    output logic [31:0]       wdata_out,
    input  logic [31:0]       rdata_in,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_data,
    output logic [4:0]        resp_rd,
    output logic [1:0]        resp_err
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    // One extra bit so addr+size never wraps before the range compare.
    localparam logic [ADDR_W:0] RAM_LIM = (ADDR_W+1)'(RAM_BYTES);

    state_t            state, state_nxt;
    logic              accept;
    logic              illegal, misal, oor;
    logic [1:0]        err;
    logic [ADDR_W:0]   req_size, end_addr;
    logic [31:0]       wdata_m;
    logic [31:0]       load_ext;
    logic [2:0]        funct3_q;
    logic              we_q;
    logic [4:0]        rd_q;

    assign accept = (state == IDLE) && req_valid && req_ready;

    // Request decode: error classification and width-masked store data.
    always_comb begin
        illegal  = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                   (req_funct3 == 3'b111) || (req_funct3[2] && req_we);
        misal    = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        req_size = '0;
        case (req_funct3[1:0])
            2'b00:   req_size[2:0] = 3'd1;
            2'b01:   req_size[2:0] = 3'd2;
            default: req_size[2:0] = 3'd4;
        endcase
        end_addr = {1'b0, req_addr} + req_size;
        oor      = end_addr > RAM_LIM;
        if (illegal)    err = 2'b11;
        else if (misal) err = 2'b01;
        else if (oor)   err = 2'b10;
        else            err = 2'b00;
        case (req_funct3[1:0])
            2'b00:   wdata_m = {24'b0, req_wdata[7:0]};
            2'b01:   wdata_m = {16'b0, req_wdata[15:0]};
            default: wdata_m = req_wdata;
        endcase
    end

    // Load extension of the RAM read data, keyed by the latched size code.
    always_comb begin
        case (funct3_q)
            3'b000:  load_ext = {{24{rdata_in[7]}}, rdata_in[7:0]};
            3'b001:  load_ext = {{16{rdata_in[15]}}, rdata_in[15:0]};
            3'b010:  load_ext = rdata_in;
            3'b100:  load_ext = {24'b0, rdata_in[7:0]};
            3'b101:  load_ext = {16'b0, rdata_in[15:0]};
            default: load_ext = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic: errors skip ACCESS so the RAM is never touched.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (err != 2'b00) ? RESP : ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs and latched request fields.
    always_ff @(posedge clk) begin
        if (!rst) begin
            req_ready  <= 1'b0;
            re_out     <= 1'b0;
            we_out     <= 1'b0;
            width_out  <= '0;
            addr_out   <= '0;
            wdata_out  <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_rd    <= '0;
            resp_err   <= '0;
            funct3_q   <= '0;
            we_q       <= 1'b0;
            rd_q       <= '0;
        end else begin
            req_ready <= (state_nxt == IDLE);
            // RAM strobe is a single-cycle pulse; cleared unless just accepted.
            re_out    <= 1'b0;
            we_out    <= 1'b0;
            width_out <= '0;
            addr_out  <= '0;
            wdata_out <= '0;
            if (accept) begin
                funct3_q <= req_funct3;
                we_q     <= req_we;
                rd_q     <= req_rd;
                if (err == 2'b00) begin
                    re_out    <= ~req_we;
                    we_out    <= req_we;
                    width_out <= req_funct3[1:0];
                    addr_out  <= req_addr;
                    wdata_out <= wdata_m;
                end else begin
                    resp_valid <= 1'b1;
                    resp_data  <= '0;
                    resp_rd    <= req_rd;
                    resp_err   <= err;
                end
            end
            if (state == ACCESS) begin
                resp_valid <= 1'b1;
                resp_data  <= we_q ? 32'b0 : load_ext;
                resp_rd    <= rd_q;
                resp_err   <= 2'b00;
            end
            if (state == RESP && resp_ready) begin
                resp_valid <= 1'b0;
                resp_data  <= '0;
                resp_rd    <= '0;
                resp_err   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: directed accesses push expected responses,
// a negedge monitor pops and compares on every response handshake.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [4:0]  req_rd = '0;
    logic        re_out, we_out;
    logic [1:0]  width_out;
    logic [31:0] addr_out, wdata_out;
    logic [31:0] rdata_in = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic [1:0]  resp_err;

    lsu_ctrl #(.RAM_BYTES(256), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rd(req_rd),
        .re_out(re_out), .we_out(we_out), .width_out(width_out),
        .addr_out(addr_out), .wdata_out(wdata_out), .rdata_in(rdata_in),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_rd(resp_rd), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  rd;
        logic [1:0]  e;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every response handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (rst && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_resp: got data %h rd %0d err %0d with no request pending",
                         resp_data, resp_rd, resp_err);
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                chk("resp", {resp_data, resp_rd, resp_err}, {x.d, x.rd, x.e});
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Issue one access; checks the RAM strobe (legal) or the direct error path.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd, input logic [31:0] rdata,
                         input logic [1:0] ew, input logic [31:0] ewd,
                         input logic [31:0] ed, input logic [1:0] ee);
        exp_t x;
        @(negedge clk);
        wait_ready();
        if (!req_ready) begin
            chk("accept_timeout", 1'b0, 1'b1);
            return;
        end
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_rd = rd;
        rdata_in = rdata; req_valid = 1'b1;
        @(posedge clk);
        x.d = ed; x.rd = rd; x.e = ee;
        exp_q.push_back(x);
        #1 req_valid = 1'b0;
        @(negedge clk);
        if (ee == 2'b00) begin
            chk("strobe", {re_out, we_out, width_out, addr_out, wdata_out},
                {~we, we, ew, addr, ewd});
            chk("resp_early", resp_valid, 1'b0);
            @(negedge clk);
            chk("strobe_off", {re_out, we_out}, 2'b00);
        end else begin
            chk("err_path", {re_out, we_out, resp_valid}, 3'b001);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || !req_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {req_ready, resp_valid, re_out, we_out, width_out, addr_out, wdata_out}, '0);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", req_ready, 1'b1);

        //    we  f3      addr        wdata         rd     rdata         ew     ewd           ed            ee
        issue(1, 3'b010, 32'h0C,  32'h01020304, 5'd3,  32'h0,        2'b10, 32'h01020304, 32'h0,        2'b00);
        issue(0, 3'b000, 32'h0D,  32'h0,        5'd5,  32'h00000080, 2'b00, 32'h0,        32'hFFFFFF80, 2'b00);
        issue(0, 3'b100, 32'h0D,  32'h0,        5'd6,  32'h00000080, 2'b00, 32'h0,        32'h00000080, 2'b00);
        issue(0, 3'b001, 32'h05,  32'h0,        5'd7,  32'h0,        2'b00, 32'h0,        32'h0,        2'b01);
        issue(0, 3'b010, 32'h100, 32'h0,        5'd8,  32'h0,        2'b00, 32'h0,        32'h0,        2'b10);
        issue(0, 3'b011, 32'h01,  32'h0,        5'd9,  32'h0,        2'b00, 32'h0,        32'h0,        2'b11);
        issue(0, 3'b001, 32'h0E,  32'h0,        5'd10, 32'h00008001, 2'b01, 32'h0,        32'hFFFF8001, 2'b00);
        issue(0, 3'b101, 32'h0E,  32'h0,        5'd11, 32'h00008001, 2'b01, 32'h0,        32'h00008001, 2'b00);
        issue(1, 3'b000, 32'h10,  32'hAABBCCDD, 5'd12, 32'h0,        2'b00, 32'h000000DD, 32'h0,        2'b00);
        issue(1, 3'b001, 32'h12,  32'hAABBCCDD, 5'd13, 32'h0,        2'b01, 32'h0000CCDD, 32'h0,        2'b00);
        issue(0, 3'b010, 32'hFC,  32'h0,        5'd14, 32'hDEADBEEF, 2'b10, 32'h0,        32'hDEADBEEF, 2'b00);
        issue(0, 3'b000, 32'hFF,  32'h0,        5'd15, 32'h0000007F, 2'b00, 32'h0,        32'h0000007F, 2'b00);
        issue(0, 3'b001, 32'hFF,  32'h0,        5'd16, 32'h0,        2'b00, 32'h0,        32'h0,        2'b01);
        issue(0, 3'b010, 32'hFD,  32'h0,        5'd17, 32'h0,        2'b00, 32'h0,        32'h0,        2'b01);
        issue(0, 3'b001, 32'hFF,  32'h0,        5'd18, 32'h0,        2'b00, 32'h0,        32'h0,        2'b01);
        issue(0, 3'b000, 32'h100, 32'h0,        5'd19, 32'h0,        2'b00, 32'h0,        32'h0,        2'b10);
        issue(1, 3'b100, 32'h20,  32'h0,        5'd20, 32'h0,        2'b00, 32'h0,        32'h0,        2'b11);
        wait_drain();

        // Backpressure: response held, new requests ignored, released later.
        resp_ready = 1'b0;
        issue(0, 3'b010, 32'h20, 32'h0, 5'd21, 32'h12345678, 2'b10, 32'h0, 32'h12345678, 2'b00);
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h24; req_wdata = 32'hFFFF0000;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_resp", {resp_valid, resp_data, resp_rd, resp_err, req_ready, we_out},
                {1'b1, 32'h12345678, 5'd21, 2'b00, 1'b0, 1'b0});
        end
        @(posedge clk);
        #1 resp_ready = 1'b1; req_valid = 1'b0;
        wait_drain();

        // Reset during ACCESS of a store: strobe dropped, no response ever.
        @(negedge clk);
        wait_ready();
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 32'h55;
        req_rd = 5'd22; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rst_access_we", we_out, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_access", {we_out, re_out, resp_valid, req_ready}, 4'b0000);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst2", req_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_resp_after_rst", resp_valid, 1'b0);
        end

        // Function still works after the mid-access reset.
        issue(0, 3'b000, 32'h40, 32'h0, 5'd23, 32'h000000FE, 2'b00, 32'h0, 32'hFFFFFFFE, 2'b00);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
